// File: rtl/prog_rom_seq.sv
// -----------------------------------------------------------------------------
// prog_rom_seq
// Writable program store and sequencer for the basic CPU. It holds DEPTH
// instruction/immediate pairs and presents one pair at a time to the decoder.
// The pair advances on a rising edge of step_i and can be redirected with a
// jump. Fetching a terminate opcode, or stepping off the end of memory when
// WRAP=0, stops the sequencer until a jump or reset.
//
// Ports
//   clk_i          clock, all logic on the rising edge
//   reset_i        synchronous active-high reset
//   step_i         advance request (level, rising edge detected internally)
//   jump_en_i      load pc from jump_addr_i (clears halt)
//   jump_addr_i    jump target, values >= DEPTH select DEPTH-1
//   wr_en_i        program-load write strobe
//   wr_addr_i      write address, values >= DEPTH are ignored
//   wr_instr_i     instruction to store
//   wr_data_i      immediate to store
//   instruction_o  current instruction (registered)
//   data_var_o     current immediate (registered)
//   pc_o           address of the entry currently presented
//   valid_o        instruction_o/data_var_o reflect mem[pc_o]
//   halted_o       sequencer stopped
// -----------------------------------------------------------------------------
module prog_rom_seq #(
    parameter int unsigned      INSTR_W  = 9,
    parameter int unsigned      DATA_W   = 16,
    parameter int unsigned      ADDR_W   = 8,
    parameter int unsigned      DEPTH    = 2**ADDR_W,
    parameter int unsigned      OPC_W    = 3,
    parameter logic [OPC_W-1:0] HALT_OPC = 3'b100,
    parameter bit               WRAP     = 1'b0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               step_i,
    input  logic               jump_en_i,
    input  logic [ADDR_W-1:0]  jump_addr_i,
    input  logic               wr_en_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [INSTR_W-1:0] wr_instr_i,
    input  logic [DATA_W-1:0]  wr_data_i,
    output logic [INSTR_W-1:0] instruction_o,
    output logic [DATA_W-1:0]  data_var_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               valid_o,
    output logic               halted_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(HALT_OPC) << (INSTR_W - OPC_W);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [DATA_W-1:0]  data;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{instr: HALT_INSTR, data: '0};

    typedef enum logic [1:0] {
        ST_RESET,
        ST_RUN,
        ST_HALT
    } state_e;

    // Program store; unprogrammed entries read as terminate so a runaway
    // program stops instead of executing garbage. Not touched by reset.
    entry_t mem_q [DEPTH] = '{default: RESET_ENTRY};

    state_e             state_q,  state_d;
    logic [ADDR_W-1:0]  pc_q,     pc_d;
    logic [INSTR_W-1:0] instr_q,  instr_d;
    logic [DATA_W-1:0]  data_q,   data_d;
    logic               valid_q,  valid_d;
    logic               halted_q, halted_d;
    logic               step_q;

    logic               step_acc_c;
    logic               fetch_c;
    logic [ADDR_W-1:0]  fetch_addr_c;
    logic [ADDR_W-1:0]  jump_tgt_c;
    logic [ADDR_W-1:0]  pc_inc_c;
    entry_t             rd_entry_c;

    // Program-load port, accepted in every state.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && (32'(wr_addr_i) < DEPTH)) begin
            mem_q[IDX_W'(wr_addr_i)] <= {wr_instr_i, wr_data_i};
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_RESET;
            pc_q     <= '0;
            instr_q  <= HALT_INSTR;
            data_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            step_q   <= step_i;
        end
    end

    // Next-state: pick at most one fetch address per cycle, then load it.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        data_d       = data_q;
        valid_d      = valid_q;
        halted_d     = halted_q;
        fetch_c      = 1'b0;
        fetch_addr_c = '0;

        // A step edge that coincides with a jump is dropped, not deferred.
        step_acc_c = step_i & ~step_q & ~halted_q & ~jump_en_i;
        jump_tgt_c = (32'(jump_addr_i) >= DEPTH) ? LAST_ADDR : jump_addr_i;
        pc_inc_c   = pc_q + ADDR_W'(1);

        case (state_q)
            ST_RESET: begin
                fetch_c      = 1'b1;
                fetch_addr_c = jump_en_i ? jump_tgt_c : '0;
            end
            ST_RUN, ST_HALT: begin
                if (jump_en_i) begin
                    fetch_c      = 1'b1;
                    fetch_addr_c = jump_tgt_c;
                end else if (step_acc_c) begin
                    if (pc_q == LAST_ADDR) begin
                        if (WRAP) begin
                            fetch_c      = 1'b1;
                            fetch_addr_c = '0;
                        end else begin
                            // Ran off the end: keep presenting the last entry.
                            halted_d = 1'b1;
                            state_d  = ST_HALT;
                        end
                    end else begin
                        fetch_c      = 1'b1;
                        fetch_addr_c = pc_inc_c;
                    end
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        // Read-first: the array is sampled before this edge's write lands.
        rd_entry_c = mem_q[IDX_W'(fetch_addr_c)];

        if (fetch_c) begin
            pc_d     = fetch_addr_c;
            instr_d  = rd_entry_c.instr;
            data_d   = rd_entry_c.data;
            valid_d  = 1'b1;
            halted_d = (rd_entry_c.instr[INSTR_W-1 -: OPC_W] == HALT_OPC);
            state_d  = halted_d ? ST_HALT : ST_RUN;
        end
    end

    assign instruction_o = instr_q;
    assign data_var_o    = data_q;
    assign pc_o          = pc_q;
    assign valid_o       = valid_q;
    assign halted_o      = halted_q;

endmodule

// File: tb/tb_prog_rom_seq.sv
// -----------------------------------------------------------------------------
// tb_prog_rom_seq
// Drives three sequencers from one stimulus stream: a full-size store without
// wrap, and two 4-entry stores with and without wrap. A behavioural model
// predicts every cycle's outputs into a queue that a monitor drains after
// each rising edge; directed checks cover the program walk-through.
// -----------------------------------------------------------------------------
module tb_prog_rom_seq;

    localparam int unsigned IW = 9;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;
    localparam int          NI = 3;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [DW-1:0] data;
        logic [AW-1:0] pc;
        logic          valid;
        logic          halted;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset, step, jump_en, wr_en;
    logic [AW-1:0] jump_addr, wr_addr;
    logic [IW-1:0] wr_instr;
    logic [DW-1:0] wr_data;

    logic [IW-1:0] ins_w [NI];
    logic [DW-1:0] dat_w [NI];
    logic [AW-1:0] pc_w  [NI];
    logic          val_w [NI];
    logic          hlt_w [NI];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prog_rom_seq #(.INSTR_W(IW), .DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .WRAP(1'b0)) u_big (
        .clk_i(clk), .reset_i(reset), .step_i(step), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_instr_i(wr_instr), .wr_data_i(wr_data),
        .instruction_o(ins_w[0]), .data_var_o(dat_w[0]), .pc_o(pc_w[0]), .valid_o(val_w[0]), .halted_o(hlt_w[0]));

    prog_rom_seq #(.INSTR_W(IW), .DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .WRAP(1'b1)) u_wrap (
        .clk_i(clk), .reset_i(reset), .step_i(step), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_instr_i(wr_instr), .wr_data_i(wr_data),
        .instruction_o(ins_w[1]), .data_var_o(dat_w[1]), .pc_o(pc_w[1]), .valid_o(val_w[1]), .halted_o(hlt_w[1]));

    prog_rom_seq #(.INSTR_W(IW), .DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .WRAP(1'b0)) u_stop (
        .clk_i(clk), .reset_i(reset), .step_i(step), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_instr_i(wr_instr), .wr_data_i(wr_data),
        .instruction_o(ins_w[2]), .data_var_o(dat_w[2]), .pc_o(pc_w[2]), .valid_o(val_w[2]), .halted_o(hlt_w[2]));

    // ---------------- reference model ----------------
    int unsigned   depth_k [NI] = '{256, 4, 4};
    bit            wrap_k  [NI] = '{1'b0, 1'b1, 1'b0};
    logic [IW-1:0] m_instr [NI][256];
    logic [DW-1:0] m_data  [NI][256];
    logic [AW-1:0] m_pc    [NI];
    logic [IW-1:0] m_ins   [NI];
    logic [DW-1:0] m_dat   [NI];
    logic          m_valid [NI];
    logic          m_halt  [NI];
    logic          m_stepq;
    obs_t          exp_q [$];

    task automatic m_load(input int k, input int unsigned a);
        m_pc[k]    = AW'(a);
        m_ins[k]   = m_instr[k][a];
        m_dat[k]   = m_data[k][a];
        m_valid[k] = 1'b1;
        m_halt[k]  = (m_ins[k][IW-1 -: 3] == 3'b100);
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_cycle();
        for (int k = 0; k < NI; k++) begin
            int unsigned lim;
            lim = depth_k[k] - 1;
            if (reset) begin
                m_pc[k] = '0; m_ins[k] = 9'h100; m_dat[k] = '0;
                m_valid[k] = 1'b0; m_halt[k] = 1'b0;
            end else if (jump_en) begin
                m_load(k, (int'(jump_addr) > int'(lim)) ? lim : int'(jump_addr));
            end else if (!m_valid[k]) begin
                m_load(k, 0);
            end else if (step && !m_stepq && !m_halt[k]) begin
                if (int'(m_pc[k]) == int'(lim)) begin
                    if (wrap_k[k]) m_load(k, 0);
                    else m_halt[k] = 1'b1;
                end else begin
                    m_load(k, int'(m_pc[k]) + 1);
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            if (wr_en && (int'(wr_addr) < int'(depth_k[k]))) begin
                m_instr[k][wr_addr] = wr_instr;
                m_data[k][wr_addr]  = wr_data;
            end
        end
        m_stepq = reset ? 1'b0 : step;
    endtask

    // Predict, queue the prediction, move to the next falling edge.
    task automatic tick();
        model_cycle();
        for (int k = 0; k < NI; k++)
            exp_q.push_back('{instr: m_ins[k], data: m_dat[k], pc: m_pc[k], valid: m_valid[k], halted: m_halt[k]});
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_step();
        step = 1'b1; tick();
        step = 1'b0; tick();
    endtask

    task automatic do_jump(input logic [AW-1:0] a);
        jump_en = 1'b1; jump_addr = a; tick();
        jump_en = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() >= NI) begin
                for (int k = 0; k < NI; k++) begin
                    e = exp_q.pop_front();
                    a = '{instr: ins_w[k], data: dat_w[k], pc: pc_w[k], valid: val_w[k], halted: hlt_w[k]};
                    n_chk++;
                    if (a !== e) begin
                        n_err++;
                        $display("FAIL sb[%0d] t=%0t got pc=%0h ins=%0h dat=%0h v=%0b h=%0b expected pc=%0h ins=%0h dat=%0h v=%0b h=%0b",
                                 k, $time, a.pc, a.instr, a.data, a.valid, a.halted,
                                 e.pc, e.instr, e.data, e.valid, e.halted);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    logic [IW-1:0] prog_i [6] = '{9'b000000000, 9'b001001000, 9'b001010000,
                                  9'b010001000, 9'b011010001, 9'b100000000};
    logic [DW-1:0] prog_d [6] = '{16'd9, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    int unsigned   wrap_pc [5] = '{1, 2, 3, 0, 1};
    int unsigned   stop_pc [5] = '{1, 2, 3, 3, 3};

    initial begin
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 256; i++) begin
                m_instr[k][i] = 9'h100;
                m_data[k][i]  = '0;
            end
            m_pc[k] = '0; m_ins[k] = 9'h100; m_dat[k] = '0; m_valid[k] = 1'b0; m_halt[k] = 1'b0;
        end
        m_stepq = 1'b0;
        reset = 1'b1; step = 1'b0; jump_en = 1'b0; jump_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_instr = '0; wr_data = '0;
        @(negedge clk);

        // Load program while held in reset.
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_instr = prog_i[i]; wr_data = prog_d[i];
            tick();
        end
        wr_en = 1'b0;
        tick();
        chk("reset_pc",     32'(pc_w[0]),  32'd0);
        chk("reset_valid",  32'(val_w[0]), 32'd0);
        chk("reset_halted", 32'(hlt_w[0]), 32'd0);
        chk("reset_instr",  32'(ins_w[0]), 32'h100);
        chk("reset_data",   32'(dat_w[0]), 32'd0);

        reset = 1'b0;
        tick();
        chk("first_valid", 32'(val_w[0]), 32'd1);
        chk("first_instr", 32'(ins_w[0]), 32'd0);
        chk("first_data",  32'(dat_w[0]), 32'd9);

        for (int s = 1; s <= 5; s++) begin
            pulse_step();
            chk($sformatf("step%0d_instr", s), 32'(ins_w[0]), 32'(prog_i[s]));
            chk($sformatf("step%0d_pc", s),    32'(pc_w[0]),  32'(s));
            chk($sformatf("wrap%0d_pc", s),    32'(pc_w[1]),  32'(wrap_pc[s-1]));
            chk($sformatf("stop%0d_pc", s),    32'(pc_w[2]),  32'(stop_pc[s-1]));
        end
        chk("term_halted", 32'(hlt_w[0]), 32'd1);
        chk("term_valid",  32'(val_w[0]), 32'd1);
        chk("end_halted",  32'(hlt_w[2]), 32'd1);
        pulse_step();
        chk("sixth_step_pc", 32'(pc_w[0]), 32'd5);

        do_jump(8'd2);
        chk("jump_pc",     32'(pc_w[0]),  32'd2);
        chk("jump_instr",  32'(ins_w[0]), 32'b001010000);
        chk("jump_halted", 32'(hlt_w[0]), 32'd0);

        step = 1'b1;
        repeat (10) tick();
        step = 1'b0;
        tick();
        chk("hold_pc", 32'(pc_w[0]), 32'd3);

        do_jump(8'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            step = (i % 2 == 0);
            tick();
        end
        step = 1'b0;
        tick();
        chk("toggle_pc", 32'(pc_w[0]), 32'd3);

        // Step edge, jump and write to the jump target in one cycle.
        step = 1'b1; jump_en = 1'b1; jump_addr = 8'd4;
        wr_en = 1'b1; wr_addr = 8'd4; wr_instr = 9'h0AA; wr_data = 16'h1234;
        tick();
        step = 1'b0; jump_en = 1'b0; wr_en = 1'b0;
        chk("coll_pc",    32'(pc_w[0]),  32'd4);
        chk("coll_instr", 32'(ins_w[0]), 32'b011010001);
        chk("coll_clamp", 32'(pc_w[1]),  32'd3);
        tick();
        do_jump(8'd4);
        chk("rejump_instr", 32'(ins_w[0]), 32'h0AA);
        chk("rejump_data",  32'(dat_w[0]), 32'h1234);

        do_jump(8'd100);
        chk("blank_instr",  32'(ins_w[0]), 32'h100);
        chk("blank_halted", 32'(hlt_w[0]), 32'd1);

        do_jump(8'd0);
        for (int i = 0; i < 3; i++) pulse_step();
        chk("pre_reset_pc", 32'(pc_w[0]), 32'd3);
        reset = 1'b1;
        tick();
        chk("midrst_pc",     32'(pc_w[0]),  32'd0);
        chk("midrst_valid",  32'(val_w[0]), 32'd0);
        chk("midrst_halted", 32'(hlt_w[0]), 32'd0);
        chk("midrst_data",   32'(dat_w[0]), 32'd0);
        reset = 1'b0;
        tick();
        chk("postrst_valid", 32'(val_w[0]), 32'd1);
        chk("postrst_data",  32'(dat_w[0]), 32'd9);
        pulse_step();
        chk("postrst_step", 32'(ins_w[0]), 32'b001001000);

        // Randomised traffic, checked by the scoreboard only.
        for (int i = 0; i < 500; i++) begin
            reset     = ($urandom_range(0, 63) == 0);
            step      = 1'($urandom_range(0, 1));
            jump_en   = ($urandom_range(0, 7) == 0);
            jump_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 20));
            wr_en     = ($urandom_range(0, 5) == 0);
            wr_addr   = AW'($urandom_range(0, 15));
            wr_instr  = IW'($urandom);
            wr_data   = DW'($urandom);
            tick();
        end
        reset = 1'b0; step = 1'b0; jump_en = 1'b0; wr_en = 1'b0;
        tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
